// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, constants and round-robin helper for the UART TX arbiter
package uart_arb_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int RR_MAX_N    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // One-hot pick of the first set bit scanning upward from last+1, wrapping at n.
    function automatic logic [RR_MAX_N-1:0] rr_pick(
        input logic [RR_MAX_N-1:0] req,
        input logic [2:0]          last,
        input int                  n
    );
        logic [RR_MAX_N-1:0] pick;
        logic                found;
        logic [2:0]          idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX_N; k++) begin
            if (k <= n) begin
                idx = 3'((int'(last) + k) % n);
                if (!found && req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester byte streams and UART TX byte port
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]                  req_valid;
    logic [N_REQ-1:0][UART_BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]                  req_last;
    logic [N_REQ-1:0]                  req_ready;
    logic                              tx_valid;
    logic [UART_BYTE_W-1:0]            tx_data;
    logic                              tx_ready;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot pick
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int LW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [LW-1:0]    i_last,
    output logic [N_REQ-1:0] o_grant
);
    logic [RR_MAX_N-1:0] w_req_ext;
    logic [RR_MAX_N-1:0] w_pick_ext;
    logic                w_unused_pick;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[N_REQ-1:0]   = i_req;
    end

    assign w_pick_ext    = rr_pick(w_req_ext, 3'(i_last), N_REQ);
    assign o_grant       = w_pick_ext[N_REQ-1:0];
    // Upper lanes are always zero when N_REQ < RR_MAX_N.
    assign w_unused_pick = ^w_pick_ext;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - per-message round-robin owner of one UART TX byte port with watchdog
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_tx_arbiter_if.slave     bus,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 timeout_evt
);
    localparam int LW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [N_REQ-1:0]       r_grant;
    logic [N_REQ-1:0]       w_grant_nxt;
    logic [N_REQ-1:0]       w_pick;
    logic [LW-1:0]          r_last_owner;
    logic [LW-1:0]          w_last_owner_nxt;
    logic [LW-1:0]          w_owner_idx;
    logic                   r_tx_valid;
    logic                   w_tx_valid_nxt;
    logic [UART_BYTE_W-1:0] r_tx_data;
    logic [UART_BYTE_W-1:0] w_tx_data_nxt;
    logic [CW-1:0]          r_wd_cnt;
    logic [CW-1:0]          w_wd_cnt_nxt;
    logic                   r_busy;
    logic                   r_timeout_evt;
    logic                   w_timeout;
    logic                   w_slot_free;
    logic                   w_accept;
    logic                   w_msg_end;
    logic                   w_any_req;
    logic                   w_wd_expire;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_req   (bus.req_valid),
        .i_last  (r_last_owner),
        .o_grant (w_pick)
    );

    always_comb begin
        w_owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_owner_idx = LW'(i);
            end
        end
    end

    assign w_slot_free   = !r_tx_valid || bus.tx_ready;
    assign bus.req_ready = r_grant & {N_REQ{w_slot_free}};
    assign w_accept      = |(bus.req_valid & bus.req_ready);
    assign w_msg_end     = w_accept && |(bus.req_last & r_grant);
    assign w_any_req     = |bus.req_valid;
    // An accept in the expiring cycle keeps the grant: the stall is over.
    assign w_wd_expire   = (TIMEOUT_CYC != 0) && (r_state == OWN) && !w_accept
                           && (r_wd_cnt >= WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = OWN;
            OWN:     if (w_msg_end || w_wd_expire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt      = r_grant;
        w_last_owner_nxt = r_last_owner;
        w_wd_cnt_nxt     = r_wd_cnt;
        w_timeout        = 1'b0;
        w_tx_valid_nxt   = w_accept ? 1'b1 : (bus.tx_ready ? 1'b0 : r_tx_valid);
        w_tx_data_nxt    = w_accept ? bus.req_data[w_owner_idx] : r_tx_data;
        case (r_state)
            IDLE: begin
                w_wd_cnt_nxt = '0;
                if (w_any_req) w_grant_nxt = w_pick;
            end
            OWN: begin
                if (w_accept) begin
                    w_wd_cnt_nxt = '0;
                end else if (r_wd_cnt != '1) begin
                    w_wd_cnt_nxt = r_wd_cnt + CW'(1);
                end
                if (w_msg_end || w_wd_expire) begin
                    w_grant_nxt      = '0;
                    w_last_owner_nxt = w_owner_idx;
                    w_wd_cnt_nxt     = '0;
                end
                w_timeout = w_wd_expire;
            end
            default: w_grant_nxt = '0;
        endcase
    end

    // Reset leaves last_owner at the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant       <= '0;
            r_last_owner  <= LW'(N_REQ - 1);
            r_tx_valid    <= 1'b0;
            r_tx_data     <= '0;
            r_wd_cnt      <= '0;
            r_busy        <= 1'b0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_grant       <= w_grant_nxt;
            r_last_owner  <= w_last_owner_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_busy        <= (|w_grant_nxt) || w_tx_valid_nxt;
            r_timeout_evt <= w_timeout;
        end
    end

    assign grant        = r_grant;
    assign busy         = r_busy;
    assign timeout_evt  = r_timeout_evt;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();
    logic [N-1:0] grant;
    logic         busy;
    logic         timeout_evt;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .grant       (grant),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    typedef struct {
        logic [3:0] rv;
        logic [7:0] d;
        logic [3:0] last;
        logic       txr;
        logic [3:0] e_grant;
        logic [3:0] e_ready;
        logic       e_txv;
        logic [7:0] e_txd;
        logic       e_busy;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model: owner as an index (-1 = none), idle-cycle count, output byte slot.
    int         m_owner, m_last, m_idle;
    logic       m_txv, m_tevt;
    logic [7:0] m_txd;

    vec_t       tbl[11];
    vec_t       cur;
    bit         vec_on = 0;
    bit         hand_on = 0;
    logic [3:0] hand_grant;
    logic       hand_evt;
    bit         drv_en = 0;
    bit         silent[N];
    logic [8:0] src_q[N][$];
    logic [7:0] out_q[$];
    int         n_in, n_out;
    logic       prev_stall;
    logic [7:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_grant();
        return (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_idle = 0;
        m_txv = 1'b0; m_tevt = 1'b0; m_txd = 8'h00;
        prev_stall = 1'b0;
    endtask

    task automatic model_step();
        int  own;
        bit  acc;
        bit  found;
        own = m_owner;
        acc = (own >= 0) && bus.req_valid[own] && (!m_txv || bus.tx_ready);
        m_tevt = 1'b0;
        if (acc) begin
            m_txd = bus.req_data[own];
            m_txv = 1'b1;
        end else if (bus.tx_ready) begin
            m_txv = 1'b0;
        end
        if (own < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && bus.req_valid[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    found = 1;
                end
            end
            m_idle = 0;
        end else if (acc) begin
            m_idle = 0;
            if (bus.req_last[own]) begin
                m_last = own;
                m_owner = -1;
            end
        end else begin
            m_idle++;
            if (m_idle >= TO) begin
                m_tevt = 1'b1; m_last = own; m_owner = -1; m_idle = 0;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !silent[i]) begin
                bus.req_valid[i] = 1'b1;
                bus.req_data[i]  = src_q[i][0][7:0];
                bus.req_last[i]  = src_q[i][0][8];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_data[i]  = 8'($urandom);
                bus.req_last[i]  = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        logic [3:0] acc;
        @(negedge clk);
        chk("grant", 32'(grant), 32'(m_grant()));
        chk("req_ready", 32'(bus.req_ready), 32'(m_grant() & {4{!m_txv || bus.tx_ready}}));
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
        chk("tx_data", 32'(bus.tx_data), 32'(m_txd));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || m_txv));
        chk("timeout_evt", 32'(timeout_evt), 32'(m_tevt));
        if (prev_stall) chk("stall_hold", 32'({bus.tx_valid, bus.tx_data}), 32'({1'b1, prev_data}));
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        if (vec_on) begin
            chk("vec_grant", 32'(grant), 32'(cur.e_grant));
            chk("vec_ready", 32'(bus.req_ready), 32'(cur.e_ready));
            chk("vec_txv", 32'(bus.tx_valid), 32'(cur.e_txv));
            chk("vec_txd", 32'(bus.tx_data), 32'(cur.e_txd));
            chk("vec_busy", 32'(busy), 32'(cur.e_busy));
        end
        if (hand_on) begin
            chk("hand_grant", 32'(grant), 32'(hand_grant));
            chk("hand_evt", 32'(timeout_evt), 32'(hand_evt));
        end
        acc = bus.req_valid & bus.req_ready;
        n_in += $countones(acc);
        if (bus.tx_valid && bus.tx_ready) begin
            out_q.push_back(bus.tx_data);
            n_out++;
        end
        model_step();
        @(posedge clk);
        #1;
        if (drv_en) begin
            for (int i = 0; i < N; i++) if (acc[i]) void'(src_q[i].pop_front());
            drive();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout_evt"}, 32'(timeout_evt), 32'd0);
    endtask

    task automatic set_in(input logic [3:0] rv, input logic [7:0] d, input logic [3:0] last, input logic txr);
        bus.req_valid = rv;
        bus.req_data  = {4{d}};
        bus.req_last  = last;
        bus.tx_ready  = txr;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drv_en = 0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            silent[i] = 0;
        end
        set_in(4'b0, 8'h00, 4'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        model_reset();
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic [7:0] d, input logic [3:0] last,
                                input logic txr, input logic [3:0] eg, input logic [3:0] er,
                                input logic ev, input logic [7:0] ed, input logic eb);
        vec_t v;
        v.rv = rv; v.d = d; v.last = last; v.txr = txr;
        v.e_grant = eg; v.e_ready = er; v.e_txv = ev; v.e_txd = ed; v.e_busy = eb;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_ni[4];
        int         len;
        bit         done;

        tbl[0]  = mk(4'b0100, 8'h41, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0);
        tbl[1]  = mk(4'b0100, 8'h41, 4'b0000, 1, 4'b0100, 4'b0100, 0, 8'h00, 1);
        tbl[2]  = mk(4'b0100, 8'h42, 4'b0100, 1, 4'b0100, 4'b0100, 1, 8'h41, 1);
        tbl[3]  = mk(4'b0000, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'h42, 1);
        tbl[4]  = mk(4'b0000, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h42, 0);
        tbl[5]  = mk(4'b0001, 8'h77, 4'b0001, 0, 4'b0000, 4'b0000, 0, 8'h42, 0);
        tbl[6]  = mk(4'b0001, 8'h77, 4'b0001, 0, 4'b0001, 4'b0001, 0, 8'h42, 1);
        tbl[7]  = mk(4'b0000, 8'h00, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'h77, 1);
        tbl[8]  = mk(4'b0000, 8'h00, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'h77, 1);
        tbl[9]  = mk(4'b0000, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'h77, 1);
        tbl[10] = mk(4'b0000, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h77, 0);
        n_in = 0; n_out = 0;

        do_reset();
        vec_on = 1;
        for (int v = 0; v < 11; v++) begin
            set_in(tbl[v].rv, tbl[v].d, tbl[v].last, tbl[v].txr);
            cur = tbl[v];
            tick();
        end
        vec_on = 0;

        // Round-robin: every requester holds a 1-byte message.
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_last  = 4'b1111;
        bus.tx_ready  = 1'b1;
        hand_on = 1;
        for (int c = 0; c < 10; c++) begin
            hand_grant = (c % 2 == 1) ? 4'(1 << (((c - 1) / 2) % 4)) : 4'b0;
            hand_evt = 1'b0;
            tick();
        end
        hand_on = 0;

        // No interleave with a toggling tx_ready.
        do_reset();
        src_q[0] = '{9'h0A0, 9'h0A1, 9'h1A2};
        src_q[1] = '{9'h1B0};
        out_q.delete();
        drv_en = 1;
        drive();
        bus.tx_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            bus.tx_ready = !bus.tx_ready;
        end
        drv_en = 0;
        exp_ni = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
        chk("nointl_len", 32'(out_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < out_q.size()) chk("nointl_byte", 32'(out_q[k]), 32'(exp_ni[k]));
        end

        // Timeout: requester 3 stalls after one byte, requester 0 waits.
        do_reset();
        hand_on = 1;
        for (int c = 0; c <= 20; c++) begin
            if (c <= 1) set_in(4'b1000, 8'h33, 4'b0000, 1'b1);
            else        set_in(4'b0001, 8'h44, 4'b0001, 1'b1);
            hand_grant = (c >= 1 && c <= 17) ? 4'b1000 : (c == 19) ? 4'b0001 : 4'b0000;
            hand_evt = (c == 18);
            tick();
        end

        // Race: accept on the cycle the watchdog would expire restarts it.
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            if (c <= 1)       set_in(4'b1000, 8'h55, 4'b0000, 1'b1);
            else if (c == 17) set_in(4'b1000, 8'h66, 4'b0000, 1'b1);
            else              set_in(4'b0000, 8'h00, 4'b0000, 1'b1);
            hand_grant = (c >= 1 && c <= 33) ? 4'b1000 : 4'b0000;
            hand_evt = (c == 34);
            tick();
        end
        hand_on = 0;

        // Reset mid-message.
        do_reset();
        set_in(4'b0001, 8'h5A, 4'b0000, 1'b1);
        for (int c = 0; c < 3; c++) tick();
        reset_n = 1'b0;
        bus.req_valid = 4'b0011;
        #1;
        chk_reset_vals("midreset");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        hand_on = 1;
        for (int c = 0; c < 2; c++) begin
            hand_grant = (c == 1) ? 4'b0001 : 4'b0000;
            hand_evt = 1'b0;
            tick();
        end
        hand_on = 0;

        // Randomized traffic with stalls against the reference model.
        do_reset();
        n_in = 0; n_out = 0;
        drv_en = 1;
        drive();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(7) == 0) begin
                    len = int'($urandom_range(4, 1));
                    for (int b = 0; b < len; b++)
                        src_q[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
                if ($urandom_range(47) == 0) silent[i] = !silent[i];
            end
            drive();
            bus.tx_ready = ($urandom_range(3) != 0);
            tick();
        end
        for (int i = 0; i < N; i++) silent[i] = 0;
        done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            drive();
            bus.tx_ready = 1'b1;
            tick();
            done = !busy && src_q[0].size() == 0 && src_q[1].size() == 0
                   && src_q[2].size() == 0 && src_q[3].size() == 0;
        end
        chk("drain_done", 32'(done), 32'd1);
        chk("byte_count", 32'(n_out), 32'(n_in));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one synthesizable UART transmitter byte port among `N_REQ` message sources, such as the debug/status reporters and the control-readback path. Ownership is granted per message, and requesters are served round-robin. A message is a byte stream terminated by `req_last`, and its bytes are never interleaved with another requester's. A per-byte watchdog reclaims the transmitter from a stalled owner. The block sits between the control logic and the UART TX core.

## Interface
- `N_REQ`, 4: number of requesters, range 2..8.
- `TIMEOUT_CYC`, 1_000_000: maximum number of cycles an owner may go without presenting a byte; 0 disables the watchdog.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: requester i presents a byte.
- `req_data` in `N_REQ`×8: byte of requester i, packed `[N_REQ-1:0][7:0]`.
- `req_last` in `N_REQ`: the presented byte ends the message.
- `req_ready` out `N_REQ`: byte of requester i accepted this cycle (valid&ready).
- `tx_valid` out 1: byte available to the UART core.
- `tx_data` out 8: byte to the UART core.
- `tx_ready` in 1: UART core takes the byte (valid&ready).
- `grant` out `N_REQ`: one-hot current owner; all zero when there is no owner.
- `busy` out 1: an owner exists or `tx_valid` is high.
- `timeout_evt` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- FSM states are IDLE and OWN.
- **IDLE:**
  - If any `req_valid` is high, pick the first set bit scanning upward from `last_owner+1` with wrap-around.
  - Register `grant` to that bit and go to OWN.
  - Otherwise stay in IDLE.
- **OWN:**
  - `req_ready[owner] = !tx_valid || tx_ready`; all other `req_ready` bits are 0.
  - On an accept, load `tx_data` and set `tx_valid`, and clear the watchdog counter.
  - If the accepted byte has `req_last` set, clear `grant`, set `last_owner` to the owner, and go to IDLE.
- **Output register:**
  - `tx_valid` clears on `tx_ready` unless it is reloaded in the same cycle.
  - `tx_data` and `tx_valid` are held stable while `tx_valid && !tx_ready`.
- **Watchdog:**
  - Counts cycles in OWN without an accept.
  - When the count reaches `TIMEOUT_CYC`, pulse `timeout_evt`, clear `grant`, set `last_owner` to the owner, and go to IDLE.
  - A byte already in the output register is still delivered.
- **Boundary conditions:**
  - Owner drops `req_valid` mid-message: the grant is held, subject only to the watchdog.
  - Accept and timeout in the same cycle: the accept wins, and no `timeout_evt` is raised.
  - Last byte accepted while other requests are pending: IDLE spends exactly one cycle arbitrating, so there is one bubble.
  - A non-owner's `req_valid` or `req_last` is ignored.
  - `tx_ready` while `tx_valid` is low has no effect.
  - Reset mid-message drops the message; the UART core must be reset by the same `reset_n`.

## Timing
- **Reset values:**
  - `grant` = 0, `tx_valid` = 0, `tx_data` = 0x00, `req_ready` = 0, `busy` = 0, `timeout_evt` = 0.
  - State = IDLE, `last_owner` = `N_REQ-1`, so requester 0 wins first.
  - The watchdog counter is 0.
- **Request latency:** `req_valid` at cycle 0 in IDLE gives `grant` at cycle 1. `req_ready` can be high from cycle 1, and `tx_valid` is high at cycle 2.
- **Throughput:** one byte per cycle when `tx_ready` is held high.
- **Width:** the counter is `$clog2(TIMEOUT_CYC+1)` bits and saturates.
- **Combinational paths:** `req_ready` is the only combinational output, a function of `grant`, `tx_valid` and `tx_ready`. All other outputs are registered.

## Structure
- `uart_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, OWN};
  - the constant `UART_BYTE_W` = 8;
  - the function `rr_pick(req, last)` returning a one-hot result.
- Sub-module `rr_arbiter`: combinational round-robin pick, parameterised by `N_REQ` and reused by other shared resources.
- The top level holds the FSM, the output register and the watchdog.

## Test plan
- **Single message:** requester 2 sends "AB" (0x41, then 0x42 with `req_last`) with `tx_ready`=1.
  - `grant`=0b0100 at cycle 1.
  - `tx_data` is 0x41 and then 0x42 on consecutive cycles.
  - `grant`=0 after the last accept.
- **Round-robin:** all four requesters hold `req_valid`, each sending a 1-byte message.
  - Grant order is 0,1,2,3,0, with one IDLE cycle between grants.
- **No interleave:**
  - Stimulus: requester 0 sends 3 bytes while requester 1 requests continuously, and `tx_ready` toggles 1/0 each cycle.
  - Response: the `tx_data` sequence is r0b0, r0b1, r0b2, then r1. Data is stable while stalled.
- **Timeout:** `TIMEOUT_CYC`=16; requester 3 sends one byte without `req_last`, then goes silent.
  - `timeout_evt` pulses on exactly the 16th idle cycle.
  - `grant` clears.
  - Pending requester 0 is granted next.
- **Race:** an accept lands on the cycle the counter would reach 16.
  - No `timeout_evt`, and the counter restarts.
- **Reset mid-message:**
  - Stimulus: `reset_n` is low for 1 cycle during a transfer.
  - Response: all outputs go to their reset values immediately (async). Requester 0 wins the next arbitration.
